// File: rtl/flop_checker.sv
// Response checker for a registered flop: predicts qout LATENCY clocks after each qin
// sample, compares, counts mismatches and captures the first failing check.
module flop_checker #(
   parameter int WIDTH      = 8,
   parameter int LATENCY    = 1,
   parameter int NUM_CHECKS = 8,
   parameter int ERR_CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 dut_reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     qin,
   input  logic [WIDTH-1:0]     qout,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 first_err_valid,
   output logic [WIDTH-1:0]     first_err_exp,
   output logic [WIDTH-1:0]     first_err_act,
   output logic [7:0]           first_err_idx,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ARMED    = 2'd1,
      CHECKING = 2'd2,
      DONE     = 2'd3
   } state_t;

   state_t             state;
   logic [LATENCY-1:0] pipe_valid;
   logic [WIDTH-1:0]   pipe_data [LATENCY];
   logic [7:0]         push_count;
   logic [7:0]         check_count;

   logic               start_run;
   logic               push_valid;
   logic [WIDTH-1:0]   push_data;
   logic               pop_valid;
   logic [WIDTH-1:0]   pop_data;
   logic               mismatch;
   logic               last_check;

   assign dbg_state = state;

   // The flop clears to zero under its own reset, so that is what must come out.
   always_comb begin
      start_run  = start && ((state == IDLE) || (state == DONE));
      push_data  = dut_reset ? '0 : qin;
      push_valid = ((state == CHECKING) && (push_count < 8'(NUM_CHECKS))) ||
                   ((state == ARMED) && !dut_reset);
      pop_valid  = (state == CHECKING) && pipe_valid[LATENCY-1];
      pop_data   = pipe_data[LATENCY-1];
      mismatch   = pop_valid && (pop_data != qout);
      last_check = pop_valid && (check_count == 8'(NUM_CHECKS - 1));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pipe_valid <= '0;
         for (int i = 0; i < LATENCY; i++) pipe_data[i] <= '0;
      end else begin
         pipe_valid[0] <= push_valid && !start_run;
         pipe_data[0]  <= push_data;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1] && !start_run;
            pipe_data[i]  <= pipe_data[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_exp   <= '0;
         first_err_act   <= '0;
         first_err_idx   <= '0;
         push_count      <= '0;
         check_count     <= '0;
      end else begin
         if (push_valid) push_count <= push_count + 8'd1;
         if (pop_valid) begin
            check_count <= check_count + 8'd1;
            if (mismatch) begin
               if (err_count != '1) err_count <= err_count + 1'b1;
               // Only the first failure of a run is kept.
               if (!first_err_valid) begin
                  first_err_valid <= 1'b1;
                  first_err_exp   <= pop_data;
                  first_err_act   <= qout;
                  first_err_idx   <= check_count;
               end
            end
         end

         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state           <= ARMED;
                  busy            <= 1'b1;
                  done            <= 1'b0;
                  pass            <= 1'b0;
                  err_count       <= '0;
                  first_err_valid <= 1'b0;
                  first_err_exp   <= '0;
                  first_err_act   <= '0;
                  first_err_idx   <= '0;
                  push_count      <= '0;
                  check_count     <= '0;
               end
            end
            ARMED: begin
               if (!dut_reset) state <= CHECKING;
            end
            CHECKING: begin
               if (last_check) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_count == '0) && !mismatch;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_flop_checker.sv
// Bench for flop_checker: three checker instances (default, LATENCY=2, ERR_CNT_W=2)
// observing bench-modelled flops with selectable faults.
module tb_flop_checker;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       dut_reset;
   logic       start;
   logic [7:0] qin;
   int         mode;
   int         sel;

   always #5 clk = ~clk;

   // Reference flops: correct 1-stage, reset-ignoring 1-stage, correct 2-stage.
   logic [7:0] flop1, flop1_nr, flop2_a, flop2;
   always @(posedge clk) begin
      flop1    <= dut_reset ? 8'h00 : qin;
      flop1_nr <= qin;
      flop2_a  <= dut_reset ? 8'h00 : qin;
      flop2    <= dut_reset ? 8'h00 : flop2_a;
   end

   logic [7:0] qout_a, qout_b, qout_c;
   always_comb begin
      case (mode)
         1:       qout_a = flop1 & 8'hFE;
         2:       qout_a = flop1_nr;
         default: qout_a = flop1;
      endcase
      qout_b = (mode == 4) ? flop1 : flop2;
      qout_c = (mode == 3) ? ~flop1 : flop1;
   end

   logic       busy_a, done_a, pass_a, fev_a;
   logic [7:0] err_a, exp_a, act_a, idx_a;
   logic [1:0] dbg_a;
   logic       busy_b, done_b, pass_b, fev_b;
   logic [7:0] err_b, exp_b, act_b, idx_b;
   logic [1:0] dbg_b;
   logic       busy_c, done_c, pass_c, fev_c;
   logic [1:0] err_c;
   logic [7:0] exp_c, act_c, idx_c;
   logic [1:0] dbg_c;

   flop_checker dut_a (
      .clk(clk), .reset_n(reset_n), .dut_reset(dut_reset), .start(start),
      .qin(qin), .qout(qout_a), .busy(busy_a), .done(done_a), .pass(pass_a),
      .err_count(err_a), .first_err_valid(fev_a), .first_err_exp(exp_a),
      .first_err_act(act_a), .first_err_idx(idx_a), .dbg_state(dbg_a)
   );

   flop_checker #(.LATENCY(2)) dut_b (
      .clk(clk), .reset_n(reset_n), .dut_reset(dut_reset), .start(start),
      .qin(qin), .qout(qout_b), .busy(busy_b), .done(done_b), .pass(pass_b),
      .err_count(err_b), .first_err_valid(fev_b), .first_err_exp(exp_b),
      .first_err_act(act_b), .first_err_idx(idx_b), .dbg_state(dbg_b)
   );

   flop_checker #(.ERR_CNT_W(2)) dut_c (
      .clk(clk), .reset_n(reset_n), .dut_reset(dut_reset), .start(start),
      .qin(qin), .qout(qout_c), .busy(busy_c), .done(done_c), .pass(pass_c),
      .err_count(err_c), .first_err_valid(fev_c), .first_err_exp(exp_c),
      .first_err_act(act_c), .first_err_idx(idx_c), .dbg_state(dbg_c)
   );

   logic       busy_s, done_s, pass_s, fev_s;
   logic [7:0] err_s, exp_s, act_s, idx_s;
   logic [1:0] dbg_s;
   always_comb begin
      case (sel)
         1: begin
            busy_s = busy_b; done_s = done_b; pass_s = pass_b; fev_s = fev_b;
            err_s = err_b; exp_s = exp_b; act_s = act_b; idx_s = idx_b; dbg_s = dbg_b;
         end
         2: begin
            busy_s = busy_c; done_s = done_c; pass_s = pass_c; fev_s = fev_c;
            err_s = {6'd0, err_c}; exp_s = exp_c; act_s = act_c; idx_s = idx_c; dbg_s = dbg_c;
         end
         default: begin
            busy_s = busy_a; done_s = done_a; pass_s = pass_a; fev_s = fev_a;
            err_s = err_a; exp_s = exp_a; act_s = act_a; idx_s = idx_a; dbg_s = dbg_a;
         end
      endcase
   end

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   typedef struct {
      int         inst;
      int         mode;
      logic [7:0] base;
      logic [7:0] step;
      int         mid_rst;
      int         start_mid;
      logic [7:0] e_err;
      logic       e_pass;
      logic       e_fev;
      logic [7:0] e_exp;
      logic [7:0] e_act;
      logic [7:0] e_idx;
   } vec_t;

   vec_t vecs[7];

   task automatic run_case(input vec_t v);
      int t;
      logic [7:0] e;
      mode = v.mode;
      sel  = v.inst;
      exp_q.push_back(v.e_err);
      exp_q.push_back({7'd0, v.e_pass});
      exp_q.push_back({7'd0, v.e_fev});
      exp_q.push_back(v.e_exp);
      exp_q.push_back(v.e_act);
      exp_q.push_back(v.e_idx);

      @(negedge clk);
      start = 1'b1; dut_reset = 1'b1; qin = 8'h00;
      @(negedge clk);
      start = 1'b0;
      check("armed_busy", {7'd0, busy_s}, 8'd1);
      check("armed_done", {7'd0, done_s}, 8'd0);
      check("armed_err_clear", err_s, 8'd0);
      check("armed_fev_clear", {7'd0, fev_s}, 8'd0);
      check("armed_state", {6'd0, dbg_s}, {6'd0, S_ARMED});
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         dut_reset = (i == v.mid_rst);
         start     = (i == v.start_mid);
         qin       = 8'(v.base + v.step * 8'(i));
         @(negedge clk);
      end
      dut_reset = 1'b0;
      start     = 1'b0;
      qin       = 8'h00;

      t = 0;
      while (!done_s && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!done_s) begin
         total++;
         bad++;
         $display("FAIL done_timeout: got done=0 want done=1 within 50 cycles");
         repeat (6) e = exp_q.pop_front();
      end else begin
         e = exp_q.pop_front(); check("err_count", err_s, e);
         e = exp_q.pop_front(); check("pass", {7'd0, pass_s}, e);
         e = exp_q.pop_front(); check("first_err_valid", {7'd0, fev_s}, e);
         e = exp_q.pop_front(); check("first_err_exp", exp_s, e);
         e = exp_q.pop_front(); check("first_err_act", act_s, e);
         e = exp_q.pop_front(); check("first_err_idx", idx_s, e);
         check("done_state", {6'd0, dbg_s}, {6'd0, S_DONE});
         check("done_busy", {7'd0, busy_s}, 8'd0);
         repeat (3) @(negedge clk);
         check("done_hold", {7'd0, done_s}, 8'd1);
         check("pass_hold", {7'd0, pass_s}, {7'd0, v.e_pass});
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, {7'd0, busy_a}, 8'd0);
      check({tag, "_done"}, {7'd0, done_a}, 8'd0);
      check({tag, "_pass"}, {7'd0, pass_a}, 8'd0);
      check({tag, "_err"}, err_a, 8'd0);
      check({tag, "_fev"}, {7'd0, fev_a}, 8'd0);
      check({tag, "_fexp"}, exp_a, 8'd0);
      check({tag, "_fact"}, act_a, 8'd0);
      check({tag, "_fidx"}, idx_a, 8'd0);
      check({tag, "_state"}, {6'd0, dbg_a}, {6'd0, S_IDLE});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; start = 1'b0; dut_reset = 1'b1; qin = 8'h00;
      mode = 0; sel = 0;

      //          inst mode base   step mid st  err   pass  fev   exp    act    idx
      vecs[0] = '{0, 0, 8'h00, 8'h01, -1, -1, 8'd0, 1'b1, 1'b0, 8'h00, 8'h00, 8'd0};
      vecs[1] = '{0, 1, 8'h00, 8'h01, -1, -1, 8'd4, 1'b0, 1'b1, 8'h01, 8'h00, 8'd1};
      vecs[2] = '{0, 2, 8'hA5, 8'h00,  3, -1, 8'd1, 1'b0, 1'b1, 8'h00, 8'hA5, 8'd3};
      vecs[3] = '{1, 0, 8'h10, 8'h01, -1, -1, 8'd0, 1'b1, 1'b0, 8'h00, 8'h00, 8'd0};
      vecs[4] = '{1, 4, 8'h10, 8'h01, -1, -1, 8'd8, 1'b0, 1'b1, 8'h10, 8'h11, 8'd0};
      vecs[5] = '{2, 3, 8'h00, 8'h01, -1, -1, 8'd3, 1'b0, 1'b1, 8'h00, 8'hFF, 8'd0};
      vecs[6] = '{0, 0, 8'h20, 8'h03, -1,  4, 8'd0, 1'b1, 1'b0, 8'h00, 8'h00, 8'd0};

      repeat (2) @(negedge clk);
      check_all_zero("reset");
      reset_n = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 7; k++) run_case(vecs[k]);

      // Abort mid-run with reset_n, after one error has been recorded.
      mode = 1; sel = 0;
      @(negedge clk);
      start = 1'b1; dut_reset = 1'b1; qin = 8'h00;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         dut_reset = 1'b0;
         qin       = 8'(i);
         @(negedge clk);
      end
      check("pre_abort_busy", {7'd0, busy_a}, 8'd1);
      check("pre_abort_err", err_a, 8'd1);
      reset_n = 1'b0;
      #1;
      check_all_zero("abort");
      @(negedge clk);
      reset_n = 1'b1;
      qin = 8'h00;
      repeat (2) @(negedge clk);
      check("post_abort_state", {6'd0, dbg_a}, {6'd0, S_IDLE});

      run_case(vecs[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
